// File: rtl/reg_seq_pkg.sv
// Shared opcode and state definitions for the register sequencer.
// Imported by the sequencer and its bench.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_CLR  = 3'b001,
        OP_LOAD = 3'b010,
        OP_INC  = 3'b011,
        OP_DEC  = 3'b100,
        OP_SHR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ops that repeat their strobe cmd_amt times.
    function automatic logic is_repeat(op_e op);
        return op inside {OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_ROR};
    endfunction

endpackage

// File: rtl/reg_sequencer.sv
// Command sequencer issuing one-hot control strobes to an external register.
// All outputs decode from registered state; reg_q only feeds the rotate bit.
module reg_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [AMT_WIDTH-1:0]  cmd_amt,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_fill,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] reg_q,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic [DATA_WIDTH-1:0] in,
    output logic                  ir,
    output logic                  il,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
    op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fill_q, fill_d;
    logic                  fire;
    logic                  unused_reg_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        fill_d  = fill_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    cnt_d   = cmd_amt;
                    data_d  = cmd_data;
                    fill_d  = cmd_fill;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // The last strobe (or an empty repeat) ends EXEC.
                if (abort || !is_repeat(op_q)
                    || cnt_q <= AMT_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cl   = 1'b0;
        ld   = 1'b0;
        inc  = 1'b0;
        dec  = 1'b0;
        sr   = 1'b0;
        sl   = 1'b0;
        fire = (state_q == S_EXEC)
            && (!is_repeat(op_q) || cnt_q != '0);
        if (fire) begin
            case (op_q)
                OP_CLR:  cl  = 1'b1;
                OP_LOAD: ld  = 1'b1;
                OP_INC:  inc = 1'b1;
                OP_DEC:  dec = 1'b1;
                OP_SHR:  sr  = 1'b1;
                OP_ROR:  sr  = 1'b1;
                OP_SHL:  sl  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ir = 1'b0;
        il = 1'b0;
        case (op_q)
            OP_SHR:  ir = fill_q;
            OP_SHL:  il = fill_q;
            OP_ROR:  ir = reg_q[0];
            default: ;
        endcase
    end

    assign in              = data_q;
    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign unused_reg_bits = ^reg_q[DATA_WIDTH-1:1];

endmodule

// File: tb/tb_reg_sequencer.sv
// Randomized bench for reg_sequencer: a cycle-schedule model checked every
// cycle, plus directed commands with hand-computed expectations.
module tb_reg_sequencer;
    import reg_seq_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_amt = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_fill = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] reg_val = '0;
    logic          cl, ld, inc, dec, sr, sl;
    logic [DW-1:0] in;
    logic          ir, il, busy, done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reg_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt),
        .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .abort(abort), .reg_q(reg_val),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .in(in), .ir(ir), .il(il),
        .busy(busy), .done(done)
    );

    // Controlled register driven by the strobes.
    always @(posedge clk) begin
        if (cl)       reg_val <= '0;
        else if (ld)  reg_val <= in;
        else if (inc) reg_val <= reg_val + 16'd1;
        else if (dec) reg_val <= reg_val - 16'd1;
        else if (sr)  reg_val <= {ir, reg_val[DW-1:1]};
        else if (sl)  reg_val <= {reg_val[DW-2:0], il};
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: a queue of per-cycle expectations, one entry per busy cycle.
    typedef struct {
        logic [5:0] strb;
        bit         fin;
    } ent_t;

    ent_t       sched[$];
    logic [2:0] m_op = 3'd0;
    logic [DW-1:0] m_data = '0;
    logic       m_fill = 1'b0;

    // {cl,ld,inc,dec,sr,sl}
    function automatic logic [5:0] op_strobe(logic [2:0] op);
        case (op)
            3'b001: return 6'b100000;
            3'b010: return 6'b010000;
            3'b011: return 6'b001000;
            3'b100: return 6'b000100;
            3'b101: return 6'b000010;
            3'b111: return 6'b000010;
            3'b110: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        ent_t h;
        ent_t e;
        int   n;
        bit   rep;
        if (!rst_n) begin
            sched.delete();
            m_op = 3'd0;
            m_data = '0;
            m_fill = 1'b0;
        end else if (sched.size() != 0) begin
            h = sched.pop_front();
            if (!h.fin && abort)
                while (sched.size() != 0 && !sched[0].fin)
                    void'(sched.pop_front());
        end else if (cmd_valid) begin
            m_op = cmd_op;
            m_data = cmd_data;
            m_fill = cmd_fill;
            rep = (cmd_op >= 3'd3);
            n = (rep && cmd_amt != 0) ? int'(cmd_amt) : 1;
            for (int i = 0; i < n; i++) begin
                e.fin = 1'b0;
                e.strb = (rep && cmd_amt == 0) ? 6'b0 : op_strobe(cmd_op);
                sched.push_back(e);
            end
            e.fin = 1'b1;
            e.strb = 6'b0;
            sched.push_back(e);
        end
    end

    always @(negedge clk) begin : compare
        logic [26:0] expv;
        logic [26:0] actv;
        logic [5:0]  es;
        logic        er, eb, ed, eir, eil;
        er = (sched.size() == 0);
        eb = !er;
        ed = !er && sched[0].fin;
        es = er ? 6'b0 : sched[0].strb;
        eir = (m_op == 3'b101) ? m_fill
            : (m_op == 3'b111) ? reg_val[0] : 1'b0;
        eil = (m_op == 3'b110) ? m_fill : 1'b0;
        expv = {er, eb, ed, es, eir, eil, m_data};
        actv = {cmd_ready, busy, done, cl, ld, inc, dec, sr, sl, ir, il, in};
        check("cycle", 32'(actv), 32'(expv));
    end

    function automatic logic [26:0] outs();
        return {cmd_ready, busy, done, cl, ld, inc, dec, sr, sl, ir, il, in};
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] amt,
                           input logic [DW-1:0] data, input logic fill,
                           input int abort_at, input bit hold,
                           output int ns, output int dc,
                           output int rc, output int dn);
        bit aborted;
        @(negedge clk);
        cmd_op = op;
        cmd_amt = amt;
        cmd_data = data;
        cmd_fill = fill;
        cmd_valid = 1'b1;
        @(posedge clk);
        ns = 0; dc = 0; rc = 0; dn = 0;
        aborted = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            abort = 1'b0;
            if (cl | ld | inc | dec | sr | sl) ns++;
            if (done) begin
                dn++;
                dc = k;
            end
            if (abort_at > 0 && !aborted && ns == abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            if (cmd_ready) begin
                rc = k;
                break;
            end
        end
        abort = 1'b0;
        if (!hold) cmd_valid = 1'b0;
    endtask

    int ns, dc, rc, dn;

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'h0400_0000);

        run_cmd(3'b010, 4'd7, 16'hA5C3, 1'b0, 0, 0, ns, dc, rc, dn);
        check("load_strobes", ns, 1);
        check("load_done", dc, 2);
        check("load_ready", rc, 3);
        check("load_reg", 32'(reg_val), 32'h0000_A5C3);

        run_cmd(3'b010, 4'd0, 16'hFFFE, 1'b0, 0, 0, ns, dc, rc, dn);
        run_cmd(3'b011, 4'd5, 16'h1234, 1'b0, 0, 0, ns, dc, rc, dn);
        check("inc_strobes", ns, 5);
        check("inc_done", dc, 6);
        check("inc_reg", 32'(reg_val), 32'h0000_0003);

        run_cmd(3'b010, 4'd0, 16'h0001, 1'b0, 0, 0, ns, dc, rc, dn);
        run_cmd(3'b110, 4'd4, 16'h0001, 1'b1, 0, 0, ns, dc, rc, dn);
        check("shl_strobes", ns, 4);
        check("shl_reg", 32'(reg_val), 32'h0000_001F);

        run_cmd(3'b010, 4'd0, 16'h0001, 1'b0, 0, 0, ns, dc, rc, dn);
        run_cmd(3'b111, 4'd1, 16'h0001, 1'b0, 0, 0, ns, dc, rc, dn);
        check("ror_reg", 32'(reg_val), 32'h0000_8000);

        run_cmd(3'b100, 4'd15, 16'h0001, 1'b0, 3, 0, ns, dc, rc, dn);
        check("abort_strobes", ns, 3);
        check("abort_done_cnt", dn, 1);
        check("abort_done", dc, 4);
        check("abort_ready", rc, 5);

        run_cmd(3'b101, 4'd15, 16'h0000, 1'b0, 0, 0, ns, dc, rc, dn);
        check("shr15_strobes", ns, 15);
        check("shr15_done", dc, 16);

        run_cmd(3'b011, 4'd0, 16'h0000, 1'b0, 0, 1, ns, dc, rc, dn);
        check("inc0_strobes", ns, 0);
        check("inc0_done", dc, 2);
        check("inc0_ready", rc, 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_accept", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);

        cmd_op = 3'b101;
        cmd_amt = 4'd8;
        cmd_data = 16'h5A5A;
        cmd_fill = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        ns = 0;
        for (int k = 0; k < 20 && ns < 2; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (sr) ns++;
        end
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outs", 32'(outs()), 32'h0400_0000);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ns = 0;
        repeat (12) begin
            @(negedge clk);
            if (cl | ld | inc | dec | sr | sl) ns++;
        end
        check("rst_no_strobe", ns, 0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        repeat (1500) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op = 3'($urandom);
            cmd_amt = AW'($urandom);
            cmd_data = DW'($urandom);
            cmd_fill = 1'($urandom);
            abort = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_sequencer.md
REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the data path to the controlled register.
REQ-002 Parameter AMT_WIDTH, default 4, SHALL set the width of the repeat count.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  3  opcode: 000 NOP, 001 CLR, 010 LOAD, 011 INC, 100 DEC, 101 SHR, 110 SHL, 111 ROR.
REQ-008 cmd_amt  input  AMT_WIDTH  repeat count for INC/DEC/SHR/SHL/ROR.
REQ-009 cmd_data  input  DATA_WIDTH  LOAD value.
REQ-010 cmd_fill  input  1  serial fill bit for SHR/SHL.
REQ-011 abort  input  1  synchronous stop of the current command.
REQ-012 reg_q  input  DATA_WIDTH  current value of the controlled register.
REQ-013 cl, ld, inc, dec, sr, sl  output  1 each  one-hot register control strobes.
REQ-014 in  output  DATA_WIDTH  load data to the register.
REQ-015 ir, il  output  1 each  serial bits for right and left shifts.
REQ-016 busy  output  1  command in progress.
REQ-017 done  output  1  single-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, DONE.
REQ-019 In IDLE, cmd_ready SHALL be 1; in EXEC and DONE it SHALL be 0.
REQ-020 A handshake (cmd_valid & cmd_ready) SHALL latch op, amt, data, and fill, then move the FSM to EXEC.
REQ-021 When cmd_ready is 0, cmd_valid SHALL be ignored.
REQ-022 CLR, LOAD, and NOP SHALL execute exactly 1 EXEC cycle regardless of amt.
  - CLR asserts cl.
  - LOAD asserts ld.
  - NOP asserts no strobe.
REQ-023 INC, DEC, SHR, SHL, and ROR SHALL issue exactly amt consecutive single-cycle strobes, one per EXEC cycle.
REQ-024 If amt is 0, an INC/DEC/SHR/SHL/ROR SHALL spend 1 EXEC cycle with no strobe.
REQ-025 Latency: for a handshake at edge T:
  - strobes occupy cycles T+1 .. T+N, where N = max(1, effective count);
  - done = 1 in cycle T+N+1 (DONE state);
  - cmd_ready = 1 again from cycle T+N+2.
REQ-026 At most one of cl, ld, inc, dec, sr, sl SHALL be 1 in any cycle; all SHALL be 0 outside EXEC.
REQ-027 All outputs SHALL be decoded from registered state only, with no combinational path from cmd_* or abort.
REQ-028 in SHALL equal the latched cmd_data from acceptance until the next acceptance.
REQ-029 Serial bit selection:
  - SHR: ir = latched fill.
  - SHL: il = latched fill.
  - ROR: ir = reg_q[0].
  - Otherwise ir = il = 0.
REQ-030 The repeat counter SHALL be AMT_WIDTH bits and count down to 0 with no wrap-around; amt = 2^AMT_WIDTH-1 SHALL produce exactly that many strobes.
REQ-031 abort sampled 1 in EXEC SHALL move the FSM to DONE at the next edge.
  - No further strobes are issued after that edge.
  - done pulses once.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 busy SHALL be 1 exactly in EXEC and DONE.

Reset
REQ-034 While rst_n = 0, the block SHALL hold this state regardless of clk:
  - FSM in IDLE;
  - counter, latched op, data, and fill all 0;
  - all strobes, in, ir, il, busy, and done at 0;
  - cmd_ready at 1.
REQ-035 Reset asserted mid-command SHALL discard the command and issue no further strobe after release.

Structure
REQ-036 The shared package reg_seq_pkg SHALL hold the opcode constants and the IDLE/EXEC/DONE state encoding.
REQ-037 The block SHALL be a single module with no sub-module; the repeat counter is inline.

Verification
REQ-038 The bench SHALL instantiate reg_sequencer driving a DATA_WIDTH=16 register model whose out feeds reg_q, and SHALL cover:
  - LOAD data=0xA5C3 -> ld high 1 cycle; register = 0xA5C3; done at T+2; cmd_ready at T+3.
  - INC amt=5 from 0xFFFE -> 5 inc strobes; register = 0x0003; done at T+6.
  - SHL amt=4, fill=1 on 0x0001 -> register = 0x001F after 4 strobes; ROR amt=1 on 0x0001 -> 0x8000.
  - DEC amt=15 with abort at 3rd strobe cycle -> 3 dec strobes only; done pulses once; busy low 1 cycle later.
  - INC amt=0 -> no strobe; done at T+2; cmd_valid held during EXEC and DONE -> not accepted until cmd_ready returns.
  - rst_n low during SHR amt=8 after 2 strobes -> outputs 0 and cmd_ready = 1 immediately; no strobe after release.
